// File: rtl/fpu_rshift_pipe.sv
// Pipelined right shifter for mantissa alignment: logical/arithmetic fill, sticky OR of
// discarded bits, opaque tag passthrough, and a single global stall enable for flow control.
module fpu_rshift_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 6,
  parameter int unsigned PIPE  = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_arith,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky,
  output logic [TAG_W-1:0] out_tag
);

  // First shift level handled by stage s; earlier stages take the leftover levels.
  function automatic int unsigned lvl_lo(int unsigned s);
    int unsigned lo;
    lo = 0;
    for (int unsigned i = 0; i < s; i++)
      lo += SHW / PIPE + ((i < SHW % PIPE) ? 1 : 0);
    return lo;
  endfunction

  function automatic logic [WIDTH-1:0] shr_fill(logic [WIDTH-1:0] d, logic f, int unsigned amt);
    logic [2*WIDTH-1:0] t;
    t = {{WIDTH{f}}, d} >> amt;
    return t[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] low_mask(int unsigned amt);
    logic [WIDTH-1:0] m;
    for (int unsigned i = 0; i < WIDTH; i++)
      m[i] = (i < amt);
    return m;
  endfunction

  logic             v_q  [PIPE];
  logic [WIDTH-1:0] d_q  [PIPE];
  logic [SHW-1:0]   sh_q [PIPE];
  logic             f_q  [PIPE];
  logic             st_q [PIPE];
  logic [TAG_W-1:0] t_q  [PIPE];

  logic             v_n  [PIPE];
  logic [WIDTH-1:0] d_n  [PIPE];
  logic [SHW-1:0]   sh_n [PIPE];
  logic             f_n  [PIPE];
  logic             st_n [PIPE];
  logic [TAG_W-1:0] t_n  [PIPE];

  logic en;
  logic in_fill;
  logic in_ovr;

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;
  assign in_fill  = in_arith & in_data[WIDTH-1];
  assign in_ovr   = {1'b0, in_shamt} >= (SHW+1)'(WIDTH);

  always_comb begin
    for (int unsigned s = 0; s < PIPE; s++) begin
      if (s == 0) begin
        v_n[s] = in_valid;
        f_n[s] = in_fill;
        t_n[s] = in_tag;
        // Overrange resolves fully here; zeroing shamt turns later levels into pass-through.
        if (in_ovr) begin
          d_n[s]  = {WIDTH{in_fill}};
          sh_n[s] = '0;
          st_n[s] = |in_data;
        end else begin
          d_n[s]  = in_data;
          sh_n[s] = in_shamt;
          st_n[s] = 1'b0;
        end
      end else begin
        v_n[s]  = v_q[s-1];
        d_n[s]  = d_q[s-1];
        sh_n[s] = sh_q[s-1];
        f_n[s]  = f_q[s-1];
        st_n[s] = st_q[s-1];
        t_n[s]  = t_q[s-1];
      end
      for (int unsigned k = 0; k < SHW; k++) begin
        if (k >= lvl_lo(s) && k < lvl_lo(s + 1) && sh_n[s][k]) begin
          st_n[s] = st_n[s] | (|(d_n[s] & low_mask(1 << k)));
          d_n[s]  = shr_fill(d_n[s], f_n[s], 1 << k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < PIPE; s++) begin
        v_q[s]  <= 1'b0;
        d_q[s]  <= '0;
        sh_q[s] <= '0;
        f_q[s]  <= 1'b0;
        st_q[s] <= 1'b0;
        t_q[s]  <= '0;
      end
    end else if (en) begin
      for (int unsigned s = 0; s < PIPE; s++) begin
        v_q[s]  <= v_n[s];
        d_q[s]  <= d_n[s];
        sh_q[s] <= sh_n[s];
        f_q[s]  <= f_n[s];
        st_q[s] <= st_n[s];
        t_q[s]  <= t_n[s];
      end
    end
  end

  assign out_valid  = v_q[PIPE-1];
  assign out_data   = d_q[PIPE-1];
  assign out_sticky = st_q[PIPE-1];
  assign out_tag    = t_q[PIPE-1];

endmodule

// File: tb/tb_fpu_rshift_pipe.sv
// Bench for fpu_rshift_pipe: several configurations share one random stream, each with its
// own reference queue; directed beats on the 32-bit/2-stage instance pin exact results.
module tb_fpu_rshift_pipe;
  localparam int unsigned NCFG  = 4;
  localparam int unsigned TAG_W = 4;

  function automatic int unsigned cfg_w(int unsigned c);
    case (c) 0: return 32; 1: return 24; 2: return 53; default: return 32; endcase
  endfunction
  function automatic int unsigned cfg_s(int unsigned c);
    case (c) 1: return 5; default: return 6; endcase
  endfunction
  function automatic int unsigned cfg_p(int unsigned c);
    case (c) 0: return 2; 1: return 1; 2: return 3; default: return 6; endcase
  endfunction

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             st;
    logic [63:0]      d;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tb_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic [63:0]      tb_data = '0;
  logic [5:0]       tb_shamt = '0;
  logic             tb_arith = 1'b0;
  logic [TAG_W-1:0] tb_tag = '0;
  logic             drain_done = 1'b0;
  int unsigned      total = 0;
  int unsigned      bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: plain shift of the w-bit operand plus sign fill and discarded-bit OR.
  function automatic logic [64:0] ref_shift(logic [63:0] din, int unsigned sh, logic ar,
                                            int unsigned w);
    logic [63:0] m, d, r;
    logic f, st;
    m = (64'd1 << w) - 64'd1;
    d = din & m;
    f = ar & d[w-1];
    if (sh >= w) begin
      r  = f ? m : '0;
      st = |d;
    end else begin
      r = d >> sh;
      if (f) r = r | (m & ~(m >> sh));
      st = |(d & ((64'd1 << sh) - 64'd1));
    end
    return {st, r};
  endfunction

  for (genvar c = 0; c < NCFG; c++) begin : g_cfg
    localparam int unsigned W = cfg_w(c);
    localparam int unsigned S = cfg_s(c);
    localparam int unsigned P = cfg_p(c);

    logic             i_ready, o_valid, o_sticky;
    logic [W-1:0]     o_data;
    logic [TAG_W-1:0] o_tag;
    exp_t             q[$];
    int unsigned      acc = 0;

    fpu_rshift_pipe #(.WIDTH(W), .SHW(S), .PIPE(P), .TAG_W(TAG_W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (tb_valid),
      .in_ready  (i_ready),
      .in_data   (tb_data[W-1:0]),
      .in_shamt  (tb_shamt[S-1:0]),
      .in_arith  (tb_arith),
      .in_tag    (tb_tag),
      .out_valid (o_valid),
      .out_ready (out_ready),
      .out_data  (o_data),
      .out_sticky(o_sticky),
      .out_tag   (o_tag)
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
      end else begin
        chk($sformatf("in_ready_c%0d", c), 64'(i_ready), 64'(!(o_valid && !out_ready)));
        if (o_valid) begin
          if (q.size() == 0) begin
            chk($sformatf("unexpected_out_c%0d", c), 64'(o_valid), 64'd0);
          end else begin
            chk($sformatf("data_c%0d", c), 64'(o_data), q[0].d);
            chk($sformatf("sticky_c%0d", c), 64'(o_sticky), 64'(q[0].st));
            chk($sformatf("tag_c%0d", c), 64'(o_tag), 64'(q[0].tag));
            if (out_ready) void'(q.pop_front());
          end
        end
        if (tb_valid && i_ready) begin
          logic [64:0] r;
          r = ref_shift(tb_data, int'(tb_shamt[S-1:0]), tb_arith, W);
          q.push_back('{tag: tb_tag, st: r[64], d: r[63:0]});
          acc++;
        end
      end
    end

    always @(posedge drain_done)
      chk($sformatf("drained_c%0d", c), 64'(q.size()), 64'd0);
  end

  task automatic send_dir(input string nm, input logic [31:0] d, input logic [5:0] sh,
                          input logic ar, input logic [31:0] ed, input logic es);
    int unsigned n;
    out_ready = 1'b1;
    tb_valid  = 1'b1;
    tb_data   = {32'h0, d};
    tb_shamt  = sh;
    tb_arith  = ar;
    tb_tag    = tb_tag + 4'd1;
    @(posedge clk); #1;
    tb_valid = 1'b0;
    n = 1;
    while (!g_cfg[0].o_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, 64'(n), 64'd2);
    chk({nm, "_data"}, 64'(g_cfg[0].o_data), 64'(ed));
    chk({nm, "_sticky"}, 64'(g_cfg[0].o_sticky), 64'(es));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int unsigned base, cyc;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_valid", 64'(g_cfg[0].o_valid), 64'd0);
    chk("rst_data", 64'(g_cfg[0].o_data), 64'd0);
    chk("rst_sticky", 64'(g_cfg[0].o_sticky), 64'd0);
    chk("rst_tag", 64'(g_cfg[0].o_tag), 64'd0);
    chk("rst_ready", 64'(g_cfg[0].i_ready), 64'd1);

    send_dir("lsr1",     32'h8000_0001, 6'd1,  1'b0, 32'h4000_0000, 1'b1);
    send_dir("asr4",     32'hF000_0000, 6'd4,  1'b1, 32'hFF00_0000, 1'b0);
    send_dir("asr40",    32'hF000_0000, 6'd40, 1'b1, 32'hFFFF_FFFF, 1'b1);
    send_dir("ovr63",    32'h0000_0001, 6'd63, 1'b0, 32'h0000_0000, 1'b1);
    send_dir("ovr32z",   32'h0000_0000, 6'd32, 1'b0, 32'h0000_0000, 1'b0);
    send_dir("sh0",      32'hA5A5_5A5A, 6'd0,  1'b1, 32'hA5A5_5A5A, 1'b0);
    send_dir("sh31neg",  32'h8000_0002, 6'd31, 1'b1, 32'hFFFF_FFFF, 1'b1);
    send_dir("sh31pos",  32'h4000_0000, 6'd31, 1'b1, 32'h0000_0000, 1'b1);
    send_dir("sh31lsr",  32'h8000_0000, 6'd31, 1'b0, 32'h0000_0001, 1'b0);
    send_dir("asr8st",   32'h8000_0100, 6'd8,  1'b1, 32'hFF80_0001, 1'b0);

    // Back-to-back stream with a three-cycle output stall in the middle.
    repeat (8) @(posedge clk);
    #1;
    base = g_cfg[0].acc;
    cyc  = 0;
    while (g_cfg[0].acc - base < 8 && cyc < 40) begin
      out_ready = !(cyc >= 3 && cyc < 6);
      tb_valid  = 1'b1;
      tb_tag    = TAG_W'(g_cfg[0].acc - base);
      tb_data   = {$urandom, $urandom};
      tb_shamt  = 6'($urandom_range(0, 63));
      tb_arith  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    tb_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_accepted", 64'(g_cfg[0].acc - base), 64'd8);
    repeat (10) @(posedge clk);
    #1;

    // Two beats in flight, then a one-cycle reset.
    tb_valid = 1'b1;
    tb_data  = 64'h1234_5678_9ABC_DEF0;
    tb_shamt = 6'd3;
    @(posedge clk); #1;
    tb_data  = 64'h0FED_CBA9_8765_4321;
    @(posedge clk); #1;
    tb_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_flush", 64'(g_cfg[0].o_valid), 64'd0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 3000; i++) begin
      tb_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       tb_data = '0;
        1:       tb_data = 64'd1 << $urandom_range(0, 63);
        default: tb_data = {$urandom, $urandom};
      endcase
      tb_shamt = 6'($urandom_range(0, 63));
      tb_arith = 1'($urandom_range(0, 1));
      tb_tag   = TAG_W'($urandom);
      @(posedge clk); #1;
    end

    tb_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1 drain_done = 1'b1;
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
